mmio_io_responder: RTL
======================

Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder between the RV32I core's data bus and the DE10-Lite board I/O.
- The core is the bus initiator. This block completes each load/store with a one-cycle-latency ack.
- Owns the LED register and raw seven-segment registers (HEX0..HEX5).
- Synchronizes switches and keys, and latches key-press events for software polling.

Parameters:
- SW_W, 10, switch input width.
- KEY_W, 2, key input width (keys active-low).
- LED_W, 10, LED output width.
- SYNC_STAGES, 2, flop stages on the SW/KEY synchronizers (minimum 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bus_req  in  1  access request; held high until bus_ack.
- bus_we  in  1  1 = store, 0 = load.
- bus_addr  in  8  byte offset within the I/O window; bits [1:0] ignored.
- bus_wdata  in  32  store data.
- bus_be  in  4  byte enables for stores.
- bus_rdata  out  32  load data; valid while bus_ack = 1.
- bus_ack  out  1  one-cycle completion pulse.
- sw_in  in  SW_W  raw switches (asynchronous).
- key_n_in  in  KEY_W  raw keys, active-low (asynchronous).
- ledr  out  LED_W  LED drive.
- hex0..hex5  out  8 each  seven-segment drive; active-low, bit 7 = decimal point.

Behaviour:
- Reset is asynchronous on reset_n low and releases on the next clk edge. Reset values:
  - ledr = 0, hex0..hex5 = 8'hFF (blank), bus_ack = 0, bus_rdata = 0, key events = 0.
  - SW synchronizer flops = 0; KEY synchronizer flops = 1 (released).
- Register map (word offsets):
  - 0x00 LED: R/W, bits [LED_W-1:0]; upper bits read 0.
  - 0x04 HEX_LO: R/W. Byte n = hex n for n = 0..3.
  - 0x08 HEX_HI: R/W. Byte 0 = hex4, byte 1 = hex5; bytes 2-3 read 0 and ignore writes.
  - 0x0C SW: RO, synchronized switches, zero-extended.
  - 0x10 KEY_EVT: bit k sets on a synchronized press of key k (1 to 0 transition of the synchronized key_n). Writing 1 to a bit clears it; writing 0 leaves it unchanged. If a set and a clear of the same bit fall in the same cycle, set wins.
  - 0x14 KEY_LVL: RO, bit k = 1 while key k is pressed (inverted synchronized level).
  - Any other offset: reads 0, writes ignored, still acked.
- Handshake FSM with states IDLE and ACK:
  - IDLE: bus_req = 1 is sampled on an edge. Stores update registers on that same edge, honouring bus_be per byte. Load data is captured into bus_rdata on that edge. Next state is ACK.
  - ACK: bus_ack = 1 for exactly one cycle. Next state is IDLE.
  - Back-to-back accesses: req still high in the cycle after ack is a new access. Peak rate is one access every 2 cycles.
  - bus_rdata holds its value outside ack. It is updated only on loads; stores leave bus_rdata unchanged.
  - req dropping in the ACK state has no effect; the transaction is already committed.
- Synchronizers:
  - Each SW/KEY bit passes through SYNC_STAGES flops.
  - Press edge detection compares the last synchronizer stage with one extra flop.
  - Latency from a raw key edge to the KEY_EVT bit set is SYNC_STAGES+1 cycles.
  - No debouncing: bounces re-set an already-set bit, which is harmless.
- A load of KEY_EVT does not clear it. Clearing is only by write-1.
- Output drive: ledr and hex outputs are driven directly from their registers. The updated value appears in the cycle after the store edge, i.e. coincident with bus_ack.
- Reset asserted mid-transaction aborts the access and drops ack; the initiator must reissue it.

Test Plan:
- Reset check: pulse reset_n low for 3 cycles. Required: ledr = 0, all hex = 8'hFF, bus_ack = 0, load of 0x10 returns 0.
- Byte-enabled store: store 0x04 data 32'h1234_5678, be = 4'b0101. Required: hex0 = 8'h78, hex2 = 8'h34, hex1 and hex3 stay 8'hFF; bus_ack high exactly 1 cycle, 2 cycles after req.
- Back-to-back access: store 0x00 data 32'h3FF, then hold req for a load of 0x00. Required: ledr = 10'h3FF; second ack at cycle 4 with bus_rdata = 32'h0000_03FF.
- Key event: drive key_n_in[1] low. Required: KEY_EVT bit 1 set 3 cycles later, and KEY_LVL load returns 32'h2.
- Write-1-to-clear: store 0x10 data 32'h2. Required: bit clears. Then make the press edge land on the same cycle as the clear store; required: bit remains 1.
- Switch readback and unmapped offsets: set sw_in = 10'h2A5, wait 3 cycles, load 0x0C. Required: 32'h0000_02A5. Load 0x1C returns 0; store 0x1C is acked with no register change.

Source files
------------

// File: rtl/mmio_io_responder.sv
// rtl/mmio_io_responder.sv - RV32I data-bus MMIO responder for DE10-Lite LEDs, HEX, switches and keys
// One-cycle-latency ack; stores commit and loads capture on the edge that samples bus_req in IDLE.
module mmio_io_responder #(
  parameter int SW_W        = 10,
  parameter int KEY_W       = 2,
  parameter int LED_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [7:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_be,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [KEY_W-1:0] key_n_in,
  output logic [LED_W-1:0] ledr,
  output logic [7:0]       hex0,
  output logic [7:0]       hex1,
  output logic [7:0]       hex2,
  output logic [7:0]       hex3,
  output logic [7:0]       hex4,
  output logic [7:0]       hex5
);

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t state_q, state_d;
  logic   access;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_req) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_ack = (state_q == ST_ACK);
    access  = (state_q == ST_IDLE) && bus_req;
  end

  logic [5:0] word;
  logic       wr_led, wr_hex_lo, wr_hex_hi, wr_evt;
  logic       unused_addr;

  assign word        = bus_addr[7:2];
  assign unused_addr = ^bus_addr[1:0];
  assign wr_led      = access && bus_we && (word == 6'd0);
  assign wr_hex_lo   = access && bus_we && (word == 6'd1);
  assign wr_hex_hi   = access && bus_we && (word == 6'd2);
  assign wr_evt      = access && bus_we && (word == 6'd4);

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Synchronizer chains: switches reset low, keys reset high (released).
  logic [SW_W-1:0]  sw_sync  [SYNC_STAGES];
  logic [KEY_W-1:0] key_sync [SYNC_STAGES];
  logic [KEY_W-1:0] key_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= '0;
        key_sync[i] <= '1;
      end
      key_prev <= '1;
    end else begin
      sw_sync[0]  <= sw_in;
      key_sync[0] <= key_n_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        key_sync[i] <= key_sync[i-1];
      end
      key_prev <= key_sync[SYNC_STAGES-1];
    end
  end

  logic [SW_W-1:0]  sw_s;
  logic [KEY_W-1:0] key_s, key_lvl, press, key_clr, evt_q;

  assign sw_s    = sw_sync[SYNC_STAGES-1];
  assign key_s   = key_sync[SYNC_STAGES-1];
  assign key_lvl = ~key_s;
  assign press   = key_prev & ~key_s;

  always_comb begin
    key_clr = '0;
    for (int k = 0; k < KEY_W; k++) begin
      key_clr[k] = wr_evt && bus_be[k/8] && bus_wdata[k];
    end
  end

  // A press landing on the same edge as a write-1 clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) evt_q <= '0;
    else          evt_q <= (evt_q & ~key_clr) | press;
  end

  logic [LED_W-1:0] led_q;
  logic [31:0]      hex_lo_q;
  logic [15:0]      hex_hi_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q    <= '0;
      hex_lo_q <= 32'hFFFF_FFFF;
      hex_hi_q <= 16'hFFFF;
    end else begin
      if (wr_led)    led_q    <= LED_W'(be_merge(32'(led_q), bus_wdata, bus_be));
      if (wr_hex_lo) hex_lo_q <= be_merge(hex_lo_q, bus_wdata, bus_be);
      if (wr_hex_hi) hex_hi_q <= 16'(be_merge({16'h0, hex_hi_q}, bus_wdata, bus_be));
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (word)
      6'd0:    rd_mux = 32'(led_q);
      6'd1:    rd_mux = hex_lo_q;
      6'd2:    rd_mux = {16'h0, hex_hi_q};
      6'd3:    rd_mux = 32'(sw_s);
      6'd4:    rd_mux = 32'(evt_q);
      6'd5:    rd_mux = 32'(key_lvl);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               bus_rdata <= '0;
    else if (access && !bus_we) bus_rdata <= rd_mux;
  end

  assign ledr = led_q;
  assign hex0 = hex_lo_q[7:0];
  assign hex1 = hex_lo_q[15:8];
  assign hex2 = hex_lo_q[23:16];
  assign hex3 = hex_lo_q[31:24];
  assign hex4 = hex_hi_q[7:0];
  assign hex5 = hex_hi_q[15:8];

endmodule
